// File: rtl/chacha_ks_xor_stream_if.sv
// chacha_ks_xor_stream_if: keystream, payload-in and result-out streams of the keystream XOR block
interface chacha_ks_xor_stream_if #(
  parameter int DATA_W = 128
);
  logic                ks_req;
  logic                ks_valid;
  logic [511:0]        ks_data;
  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic [DATA_W/8-1:0] in_keep;
  logic                in_last;
  logic                in_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [DATA_W/8-1:0] out_keep;
  logic                out_last;
  logic [DATA_W-1:0]   mac_data;
  logic                out_ready;
  modport master (
    output ks_valid, ks_data, in_valid, in_data, in_keep, in_last, out_ready,
    input  ks_req, in_ready, out_valid, out_data, out_keep, out_last, mac_data
  );
  modport slave (
    input  ks_valid, ks_data, in_valid, in_data, in_keep, in_last, out_ready,
    output ks_req, in_ready, out_valid, out_data, out_keep, out_last, mac_data
  );
endinterface

// File: rtl/chacha_ks_xor_stream.sv
// chacha_ks_xor_stream: prefetches ChaCha keystream blocks and XORs DATA_W payload beats against them
module chacha_ks_xor_stream #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 2,
  parameter int CTR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [CTR_W-1:0]      ctr_init,
  input  logic                  dir,
  chacha_ks_xor_stream_if.slave bus,
  output logic                  busy,
  output logic                  ctr_ovf,
  output logic [CTR_W-1:0]      blk_cnt
);
  localparam int SLICES = 512 / DATA_W;
  localparam int KW = DATA_W / 8;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int SW = SLICES > 1 ? $clog2(SLICES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SLICES - 1);
  localparam logic [2:0] DEP = 3'(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [511:0] blk_q [2**PW];
  logic [PW-1:0] head, tail;
  logic [SW-1:0] sidx;
  logic [2:0] cnt;
  logic pend, disc, dir_q, req, rdy, acc, push, pop;
  logic [DATA_W-1:0] ks, mask, res;
  logic out_valid, out_last;
  logic [DATA_W-1:0] out_data, mac_data;
  logic [KW-1:0] out_keep;
  assign bus.ks_req    = req;
  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_keep  = out_keep;
  assign bus.out_last  = out_last;
  assign bus.mac_data  = mac_data;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    req = state == RUN && !pend && cnt < DEP && !ctr_ovf && !cfg_we;
    rdy = state == RUN && cnt != 3'd0 && (!out_valid || bus.out_ready);
    acc = bus.in_valid && rdy;
    push = pend && bus.ks_valid && !disc && !cfg_we;
    pop = acc && (bus.in_last || sidx == S_LAST);
    ks = blk_q[head][DATA_W*sidx +: DATA_W];
    mask = '0;
    for (int i = 0; i < KW; i++) mask[8*i +: 8] = {8{bus.in_keep[i]}};
    res = (bus.in_data ^ ks) & mask;
    state_n = cfg_we ? RUN :
              (state == RUN && acc && bus.in_last) ? DRAIN :
              (state == DRAIN && out_valid && bus.out_ready && out_last) ? IDLE : state;
  end
  // A block requested before a restart still arrives; disc marks it so it is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {head, tail, sidx, cnt, pend, disc, dir_q, ctr_ovf, blk_cnt} <= '0;
      {out_valid, out_last, out_keep, out_data, mac_data} <= '0;
    end else if (cfg_we) begin
      {head, tail, sidx, cnt, ctr_ovf, out_valid} <= '0;
      blk_cnt <= ctr_init;
      dir_q <= dir;
      pend <= pend && !bus.ks_valid;
      disc <= pend && !bus.ks_valid;
    end else begin
      if (req) begin
        ctr_ovf <= &blk_cnt;
        if (!(&blk_cnt)) blk_cnt <= blk_cnt + CTR_W'(1);
      end
      pend <= req || (pend && !bus.ks_valid);
      if (pend && bus.ks_valid) disc <= 1'b0;
      if (push) tail <= tail == P_LAST ? '0 : tail + PW'(1);
      if (pop) head <= head == P_LAST ? '0 : head + PW'(1);
      sidx <= pop ? '0 : sidx + SW'(acc);
      cnt <= cnt + 3'(push) - 3'(pop);
      if (acc) begin
        out_valid <= 1'b1;
        out_data <= res;
        mac_data <= dir_q ? bus.in_data & mask : res;
        out_keep <= bus.in_keep;
        out_last <= bus.in_last;
      end else if (bus.out_ready) out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) if (push) blk_q[tail] <= bus.ks_data;
endmodule

// File: tb/tb_chacha_ks_xor_stream.sv
// tb_chacha_ks_xor_stream: randomized scoreboard bench for the keystream XOR stream block
module tb_chacha_ks_xor_stream;
  localparam int DATA_W = 128, DEPTH = 2, CTR_W = 32;
  localparam int KW = DATA_W / 8, S = 512 / DATA_W;
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] m;
    logic [KW-1:0]     k;
    logic              l;
  } beat_t;
  logic clk = 0, rst = 1, cfg_we = 0, dir = 0;
  logic [CTR_W-1:0] ctr_init = '0;
  logic busy, ctr_ovf;
  logic [CTR_W-1:0] blk_cnt;
  chacha_ks_xor_stream_if #(.DATA_W(DATA_W)) bus ();
  chacha_ks_xor_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CTR_W(CTR_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .ctr_init(ctr_init), .dir(dir),
    .bus(bus), .busy(busy), .ctr_ovf(ctr_ovf), .blk_cnt(blk_cnt)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0, n_req = 0, n_out = 0;
  bit ks_const = 0, resp_auto = 1, resp_busy = 0, rdy_force = 0, rdy_val = 1;
  bit held = 0, last_seen = 0, mdir = 0;
  logic [CTR_W-1:0] mdl_ctr = '0, mbase = '0, rc;
  logic [DATA_W-1:0] held_d;
  int lat;
  beat_t sb[$];
  beat_t e;
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Keystream is a fixed function of the block counter, so the model knows every block.
  function automatic logic [511:0] ks_of(input logic [CTR_W-1:0] c);
    logic [511:0] b;
    for (int w = 0; w < 16; w++) b[32*w +: 32] = (c * 32'h9E3779B1) ^ (32'(w) * 32'h85EBCA6B) ^ 32'h5BD1E995;
    return ks_const ? {64{8'hA5}} : b;
  endfunction
  always @(negedge clk) if (bus.ks_req) n_req++;
  initial begin
    forever begin
      @(negedge clk);
      if (resp_auto && bus.ks_req && !rst) begin
        resp_busy = 1;
        rc = mdl_ctr;
        mdl_ctr = mdl_ctr + 1;
        lat = $urandom_range(0, 3);
        @(posedge clk);
        repeat (lat) @(posedge clk);
        #1 bus.ks_valid = 1; bus.ks_data = ks_of(rc);
        @(posedge clk);
        #1 bus.ks_valid = 0; bus.ks_data = '0;
        resp_busy = 0;
      end
    end
  end
  always @(posedge clk) begin
    #1 bus.out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
  end
  always @(negedge clk) begin
    if (last_seen) begin
      check("busy_fall", busy, 0);
      last_seen = 0;
    end
    if (held && !rst) check("hold_stable", bus.out_data, held_d);
    held = bus.out_valid && !bus.out_ready && !rst;
    held_d = bus.out_data;
    if (bus.out_valid && bus.out_ready && !rst) begin
      if (sb.size() == 0) check("unexpected_beat", bus.out_valid, 0);
      else begin
        e = sb.pop_front();
        check("out_data", bus.out_data, e.d);
        check("mac_data", bus.mac_data, e.m);
        check("out_keep", bus.out_keep, e.k);
        check("out_last", bus.out_last, e.l);
        n_out++;
        if (bus.out_last) begin
          check("busy_at_last", busy, 1);
          last_seen = 1;
        end
      end
    end
  end
  task automatic cfg(input logic [CTR_W-1:0] c, input logic d);
    cfg_we = 1; ctr_init = c; dir = d;
    mdl_ctr = c; mbase = c; mdir = d;
    @(posedge clk);
    #1 cfg_we = 0;
  endtask
  task automatic beats(input int n, input bit last_en, input int gap, input int last_bytes, input bit zero);
    logic [DATA_W-1:0] d, ks;
    logic [KW-1:0] kp;
    logic [511:0] blk;
    beat_t x;
    bit ok, lst;
    int kb;
    for (int j = 0; j < n; j++) begin
      for (int w = 0; w < DATA_W / 32; w++) d[32*w +: 32] = zero ? 32'h0 : $urandom;
      lst = last_en && j == n - 1;
      kb = !lst ? KW : last_bytes != 0 ? last_bytes : int'($urandom_range(1, KW));
      kp = '0;
      for (int i = 0; i < kb; i++) kp[i] = 1'b1;
      repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
      bus.in_valid = 1; bus.in_data = d; bus.in_keep = kp; bus.in_last = lst;
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk);
        #1;
      end
      bus.in_valid = 0; bus.in_last = 0;
      check("in_accept", ok, 1);
      if (ok) begin
        blk = ks_of(mbase + CTR_W'(j / S));
        ks = blk[DATA_W*(j % S) +: DATA_W];
        x = '0;
        for (int i = 0; i < KW; i++) if (i < kb) begin
          x.d[8*i +: 8] = d[8*i +: 8] ^ ks[8*i +: 8];
          x.m[8*i +: 8] = mdir ? d[8*i +: 8] : x.d[8*i +: 8];
        end
        x.k = kp;
        x.l = lst;
        sb.push_back(x);
      end
    end
  endtask
  task automatic wait_done();
    bit done = 0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      done = !busy && sb.size() == 0;
    end
    check("msg_done", done, 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n0;
    bit seen;
    logic [DATA_W-1:0] hd;
    bus.ks_valid = 0; bus.ks_data = '0; bus.in_valid = 0; bus.in_data = '0;
    bus.in_keep = '0; bus.in_last = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ks_req", bus.ks_req, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_mac_data", bus.mac_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ctr_ovf", ctr_ovf, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    rst = 0;
    @(posedge clk);
    #1;
    ks_const = 1;
    n0 = n_req;
    cfg(1, 0);
    beats(4, 1, 0, KW, 1);
    wait_done();
    repeat (8) begin @(posedge clk); #1; end
    check("prefetch_blk_cnt", blk_cnt, 3);
    check("prefetch_reqs", n_req - n0, 2);
    ks_const = 0;
    cfg(7, 0);
    beats(2, 1, 0, 4, 0);
    wait_done();
    rdy_force = 1; rdy_val = 0;
    repeat (2) begin @(posedge clk); #1; end
    cfg(9, 0);
    n0 = n_out;
    fork
      beats(6, 1, 0, 0, 0);
    join_none
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    check("hold_first", seen, 1);
    hd = bus.out_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_data", bus.out_data, hd);
    end
    @(posedge clk);
    #1 rdy_force = 0;
    wait_done();
    check("hold_count", n_out - n0, 6);
    n0 = n_req;
    cfg(32'hFFFF_FFFF, 0);
    beats(S, 0, 1, 0, 0);
    bus.in_valid = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("ovf_stall", bus.in_ready, 0);
    end
    @(posedge clk);
    #1 bus.in_valid = 0;
    check("ovf_flag", ctr_ovf, 1);
    check("ovf_reqs", n_req - n0, 1);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = sb.size() == 0 && !bus.out_valid;
    end
    check("ovf_drain", seen, 1);
    @(posedge clk);
    #1;
    cfg(50, 0);
    @(negedge clk);
    check("ovf_clear", ctr_ovf, 0);
    @(posedge clk);
    #1;
    beats(3, 1, 1, 0, 0);
    wait_done();
    cfg(32'h1122_3344, 1);
    beats(5, 1, 1, 0, 0);
    wait_done();
    for (int m = 0; m < 12; m++) begin
      cfg(CTR_W'($urandom_range(0, 1000)), 1'($urandom_range(0, 1)));
      beats($urandom_range(1, 10), 1, 2, 0, 0);
      wait_done();
    end
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = !resp_busy;
    end
    @(posedge clk);
    #1 resp_auto = 0;
    cfg(10, 0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = bus.ks_req;
    end
    check("disc_req_seen", seen, 1);
    @(posedge clk);
    #1;
    cfg(20, 0);
    bus.ks_valid = 1; bus.ks_data = ks_of(10);
    @(posedge clk);
    #1 bus.ks_valid = 0;
    @(negedge clk);
    check("disc_occupancy", bus.in_ready, 0);
    check("disc_fresh_req", bus.ks_req, 1);
    @(posedge clk);
    #1 bus.ks_valid = 1; bus.ks_data = ks_of(20); mdl_ctr = 21;
    @(posedge clk);
    #1 bus.ks_valid = 0;
    resp_auto = 1;
    beats(4, 1, 1, 0, 0);
    wait_done();
    cfg(5, 1);
    fork
      beats(8, 1, 0, 0, 0);
    join_none
    repeat (6) @(posedge clk);
    #3 rst = 1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_data", bus.out_data, 0);
    check("arst_mac_data", bus.mac_data, 0);
    check("arst_out_keep", bus.out_keep, 0);
    check("arst_out_last", bus.out_last, 0);
    check("arst_ks_req", bus.ks_req, 0);
    check("arst_in_ready", bus.in_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_ctr_ovf", ctr_ovf, 0);
    check("arst_blk_cnt", blk_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/chacha_ks_xor_stream.md
Name: chacha_ks_xor_stream

Overview:
Parametrised keystream-XOR datapath for the ChaCha20-Poly1305 engine. Sits between the ChaCha keystream unit (512-bit blocks via req/valid) and the payload stream. It prefetches up to DEPTH keystream blocks, slices them into DATA_W beats and XORs them with payload under a byte-keep mask. In parallel it emits the ciphertext beat that the Poly1305 adapter must absorb, for both encrypt and decrypt.

Parameters:
DATA_W, 128, payload beat width in bits; legal values are 32, 64, 128, 256, 512.
DEPTH, 2, keystream blocks buffered (1..4).
CTR_W, 32, block counter width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_we  in  1  arm a new message: load counter, flush buffer
ctr_init  in  CTR_W  first block counter for the message
dir  in  1  0 = encrypt, 1 = decrypt; sampled on cfg_we
ks_req  out  1  one-cycle request for the next keystream block
ks_valid  in  1  keystream block returned
ks_data  in  512  keystream block, little-endian byte order
in_valid  in  1  payload beat valid
in_data  in  DATA_W  payload beat
in_keep  in  DATA_W/8  byte enables; contiguous from bit 0
in_last  in  1  final beat of the message
in_ready  out  1  payload beat accepted
out_valid  out  1  result beat valid
out_data  out  DATA_W  in_data XOR keystream, with masked bytes forced to 0
out_keep  out  DATA_W/8  copy of in_keep
out_last  out  1  copy of in_last
mac_data  out  DATA_W  ciphertext for Poly1305, masked like out_data
out_ready  in  1  downstream accepts the beat
busy  out  1  message armed and not yet finished
ctr_ovf  out  1  sticky flag: counter exhausted
blk_cnt  out  CTR_W  counter value of the next request

Behaviour:
- Reset: all outputs 0. Buffer empty, nothing outstanding, disarmed.
- SLICES = 512/DATA_W. Beat k of a block uses keystream bits ks_data[DATA_W*k +: DATA_W].
- Top-level states:
  - IDLE: go to RUN on cfg_we. Load blk_cnt = ctr_init and latch dir. Flush buffer, reset slice index, clear ctr_ovf, set busy.
  - RUN: stay until the beat with in_last completes its input handshake, then go to DRAIN.
  - DRAIN: stay until out_last completes its output handshake (out_valid & out_ready), then go to IDLE and clear busy.
  - cfg_we in any state restarts the message immediately (same actions as IDLE -> RUN).
- Prefetch:
  - In RUN, assert ks_req for one cycle when all of these hold: no request is outstanding, occupancy < DEPTH, and ctr_ovf = 0.
  - At most one request is outstanding at a time.
  - blk_cnt increments on each ks_req.
  - When a request is issued with blk_cnt = 2^CTR_W - 1, do not wrap: set ctr_ovf and issue no further requests.
- Buffer:
  - When a request is outstanding, ks_valid writes the block into the buffer tail.
  - ks_valid with no request outstanding is ignored.
  - If cfg_we occurs while a request is in flight, the returned block is discarded (one-bit discard flag).
- Input/output handshake:
  - in_ready = RUN & buffer not empty & (out_valid = 0 | out_ready).
  - An input handshake registers the result, so out_valid rises one cycle after in_valid & in_ready.
  - Output register holds its value stable while out_valid & !out_ready.
- Slice consumption:
  - Every accepted beat consumes one full slice, even when partially kept.
  - After SLICES beats, the head block is popped and the slice index wraps to 0.
  - On in_last, the remainder of the head block is discarded (pop) and the slice index resets.
- Masking:
  - out_data bytes with out_keep = 0 are driven 0; mac_data is masked the same way.
  - dir = 0 (encrypt): mac_data = out_data.
  - dir = 1 (decrypt): mac_data = in_data.
- ctr_ovf with an empty buffer: in_ready stays low; the message stalls until cfg_we or rst.
- Asynchronous reset mid-message: the current message is abandoned and the block returns to its reset state.

Test Plan:
- DATA_W=128, DEPTH=2. cfg_we with ctr_init=1; bench answers each ks_req with ks_data = {64{8'hA5}}. Feed 4 beats of in_data=0, keep=FFFF, in_last on beat 4 -> out_data = A5..A5 on all 4 beats; blk_cnt=3 afterwards; ks_req fires exactly twice (buffer fills) and no third request follows.
- Feed a 20-byte message: beat 1 keep=FFFF, beat 2 keep=000F with in_last -> beat 2 upper 12 bytes of out_data/mac_data are 0; busy falls the cycle after out_last is accepted; slice index returns to 0 for the next cfg_we.
- Hold out_ready=0 for 5 cycles with in_valid high -> in_ready low after the first accepted beat; out_data stable across all 5 cycles; no beat lost or duplicated once out_ready returns.
- ctr_init=32'hFFFFFFFF -> exactly one ks_req, then ctr_ovf=1. After SLICES beats, in_ready=0 and stays 0 until cfg_we clears ctr_ovf.
- dir=1 with in_data=0x1122... -> mac_data equals in_data. Repeat with dir=0 -> mac_data equals out_data.
- Assert cfg_we while a request is outstanding, then return ks_valid -> that block is dropped, occupancy stays 0 and a fresh ks_req is issued. Assert rst mid-message -> all outputs 0 on the same edge.
